// File: rtl/fifo_ctrl_dual_pop_pkg.sv
// Shared constants for the dual-pop FIFO pointer controller: pop encodings
// and the depth helper used by the controller and its wrapper.
package fifo_ctrl_dual_pop_pkg;

  // Number of words the consumer retires in a cycle; the fourth code is illegal.
  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2,
    POP_BAD  = 2'd3
  } pop_e;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 3;

  function automatic int unsigned depth_of(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage : fifo_ctrl_dual_pop_pkg

// File: rtl/fifo_ctrl_dual_pop_if.sv
// Handshake and RAM-address bundle between the dual-pop FIFO controller
// and its producer/consumer side (master) and the controller itself (slave).
interface fifo_ctrl_dual_pop_if #(
  parameter int ADDR_WIDTH = 3
);

  logic                  push;
  logic [1:0]            pop;
  logic                  clr_err;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr0;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  has_two;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, clr_err,
    input  we, w_addr, r_addr0, r_addr1, count,
    input  empty, full, has_two, overflow, underflow
  );

  modport slave (
    input  push, pop, clr_err,
    output we, w_addr, r_addr0, r_addr1, count,
    output empty, full, has_two, overflow, underflow
  );

endinterface : fifo_ctrl_dual_pop_if

// File: rtl/fifo_ctrl_dual_pop.sv
// Pointer/occupancy controller for a circular FIFO on a 1-write/2-read RAM.
// Read port 0 addresses the head word, read port 1 the word after it.
module fifo_ctrl_dual_pop
  import fifo_ctrl_dual_pop_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  fifo_ctrl_dual_pop_if.slave bus
);

  localparam int unsigned         DEPTH     = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_TWO   = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] tail_q, head_q, head_p1_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  overflow_q, underflow_q;

  logic                  full, push_ok, push_rej, pop_rej;
  logic [ADDR_WIDTH:0]   pop_n;
  logic [ADDR_WIDTH-1:0] pop_step;
  logic [ADDR_WIDTH:0]   count_d;

  // Status is a pure function of the stored count, never of this cycle's inputs.
  assign full     = (count_q == DEPTH_CNT);
  assign push_ok  = bus.push & ~full;
  assign push_rej = bus.push & full;

  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pop_n   = '0;
    pop_rej = 1'b0;
    case (bus.pop)
      POP_NONE: pop_n = '0;
      POP_ONE: begin
        if (count_q >= CNT_ONE) pop_n   = CNT_ONE;
        else                    pop_rej = 1'b1;
      end
      POP_TWO: begin
        if (count_q >= CNT_TWO) pop_n   = CNT_TWO;
        else                    pop_rej = 1'b1;
      end
      default: pop_rej = 1'b1;
    endcase
  end

  assign pop_step = pop_n[ADDR_WIDTH-1:0];
  assign count_d  = count_q + {{ADDR_WIDTH{1'b0}}, push_ok} - pop_n;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      tail_q      <= '0;
      head_q      <= '0;
      head_p1_q   <= PTR_ONE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) tail_q <= tail_q + PTR_ONE;
      head_q    <= head_q + pop_step;
      head_p1_q <= head_p1_q + pop_step;
      count_q   <= count_d;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (push_rej)         overflow_q <= 1'b1;
      else if (bus.clr_err) overflow_q <= 1'b0;

      if (pop_rej)          underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  assign bus.we        = push_ok;
  assign bus.w_addr    = tail_q;
  assign bus.r_addr0   = head_q;
  assign bus.r_addr1   = head_p1_q;
  assign bus.count     = count_q;
  assign bus.empty     = (count_q == '0);
  assign bus.full      = full;
  assign bus.has_two   = (count_q >= CNT_TWO);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule : fifo_ctrl_dual_pop

// File: tb/tb_fifo_ctrl_dual_pop.sv
// Self-checking bench for fifo_ctrl_dual_pop with a local 8x8 asynchronous-read
// RAM, a queue-based reference model and directed literal expectations.
module tb_fifo_ctrl_dual_pop;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] w_data;
  logic [7:0] mem [8];
  logic [7:0] r_data0, r_data1;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_ctrl_dual_pop_if #(.ADDR_WIDTH(3)) bus ();

  fifo_ctrl_dual_pop #(.ADDR_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Three-port RAM stand-in: synchronous write, asynchronous read.
  always @(posedge clk) if (bus.we) mem[bus.w_addr] <= w_data;
  assign r_data0 = mem[bus.r_addr0];
  assign r_data1 = mem[bus.r_addr1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored words plus the head address.
  logic [7:0] mq[$];
  int  m_head = 0;
  bit  m_ovf  = 1'b0;
  bit  m_unf  = 1'b0;

  always @(posedge clk) begin : model
    int n;
    bit rej, pok;
    if (reset) begin
      mq.delete();
      m_head = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      pok = bus.push && (mq.size() < 8);
      n   = 0;
      rej = 1'b0;
      if (bus.pop == 2'd1) begin
        if (mq.size() >= 1) n = 1; else rej = 1'b1;
      end else if (bus.pop == 2'd2) begin
        if (mq.size() >= 2) n = 2; else rej = 1'b1;
      end else if (bus.pop == 2'd3) begin
        rej = 1'b1;
      end
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      m_head = (m_head + n) % 8;
      if (pok) mq.push_back(w_data);
      if (bus.push && !pok) m_ovf = 1'b1;
      else if (bus.clr_err) m_ovf = 1'b0;
      if (rej) m_unf = 1'b1;
      else if (bus.clr_err) m_unf = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    int sz;
    if (chk_en) begin
      sz = mq.size();
      check("count",     32'(bus.count),     32'(sz));
      check("empty",     32'(bus.empty),     32'(sz == 0));
      check("full",      32'(bus.full),      32'(sz == 8));
      check("has_two",   32'(bus.has_two),   32'(sz >= 2));
      check("overflow",  32'(bus.overflow),  32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_unf));
      check("we",        32'(bus.we),        32'(bus.push && sz < 8));
      check("w_addr",    32'(bus.w_addr),    32'((m_head + sz) % 8));
      check("r_addr0",   32'(bus.r_addr0),   32'(m_head));
      check("r_addr1",   32'(bus.r_addr1),   32'((m_head + 1) % 8));
      if (sz >= 1) check("r_data0", 32'(r_data0), 32'(mq[0]));
      if (sz >= 2) check("r_data1", 32'(r_data1), 32'(mq[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 2'd0;
    bus.clr_err = 1'b0;
  endtask

  task automatic op(input bit p, input logic [1:0] pp, input bit c, input logic [7:0] d);
    bus.push    = p;
    bus.pop     = pp;
    bus.clr_err = c;
    w_data      = d;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 2'd0;
    bus.clr_err = 1'b0;
    w_data      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    check("rst_count",   32'(bus.count),   32'd0);
    check("rst_empty",   32'(bus.empty),   32'd1);
    check("rst_r_addr1", 32'(bus.r_addr1), 32'd1);

    // Fill to full, then a rejected ninth push.
    for (int i = 0; i < 8; i++) op(1'b1, 2'd0, 1'b0, 8'(8'h10 + i));
    check("fill_count",  32'(bus.count),  32'd8);
    check("fill_full",   32'(bus.full),   32'd1);
    check("fill_rd0",    32'(r_data0),    32'h10);
    check("fill_rd1",    32'(r_data1),    32'h11);
    check("fill_w_addr", 32'(bus.w_addr), 32'd0);
    bus.push = 1'b1;
    w_data   = 8'h99;
    #1;
    check("ninth_we", 32'(bus.we), 32'd0);
    tick();
    check("ninth_ovf",   32'(bus.overflow), 32'd1);
    check("ninth_count", 32'(bus.count),    32'd8);

    // Drain two at a time, checking each lookahead pair before it retires.
    for (int k = 0; k < 4; k++) begin
      check("pair_rd0", 32'(r_data0), 32'h10 + 32'(2 * k));
      check("pair_rd1", 32'(r_data1), 32'h11 + 32'(2 * k));
      op(1'b0, 2'd2, 1'b0, 8'h00);
    end
    check("drain_empty",   32'(bus.empty),   32'd1);
    check("drain_has_two", 32'(bus.has_two), 32'd0);

    // Single word, pop of two rejected, then pop of one.
    op(1'b1, 2'd0, 1'b0, 8'hA5);
    op(1'b0, 2'd2, 1'b0, 8'h00);
    check("short_unf",   32'(bus.underflow), 32'd1);
    check("short_count", 32'(bus.count),     32'd1);
    check("short_rd0",   32'(r_data0),       32'hA5);
    op(1'b0, 2'd1, 1'b0, 8'h00);
    check("short_empty", 32'(bus.empty), 32'd1);

    // Wrap: nine pushes from head 1 put head at 7 with the next word at 0.
    for (int i = 0; i < 8; i++) op(1'b1, 2'd0, 1'b0, 8'(8'h20 + i));
    repeat (3) op(1'b0, 2'd2, 1'b0, 8'h00);
    op(1'b1, 2'd0, 1'b0, 8'h28);
    check("wrap_r_addr0", 32'(bus.r_addr0), 32'd7);
    check("wrap_r_addr1", 32'(bus.r_addr1), 32'd0);
    check("wrap_rd0",     32'(r_data0),     32'h26);
    check("wrap_rd1",     32'(r_data1),     32'h27);
    op(1'b0, 2'd2, 1'b0, 8'h00);
    check("wrap_head", 32'(bus.r_addr0), 32'd1);
    check("wrap_rd0b", 32'(r_data0),     32'h28);

    // Full with push+pop: push refused; then both accepted.
    for (int i = 0; i < 7; i++) op(1'b1, 2'd0, 1'b0, 8'(8'h30 + i));
    op(1'b1, 2'd1, 1'b0, 8'h40);
    check("sim_ovf",    32'(bus.overflow), 32'd1);
    check("sim_count",  32'(bus.count),    32'd7);
    check("sim_w_addr", 32'(bus.w_addr),   32'd1);
    op(1'b1, 2'd1, 1'b0, 8'h41);
    check("sim2_count",  32'(bus.count),  32'd7);
    check("sim2_w_addr", 32'(bus.w_addr), 32'd2);

    // Illegal pop code, clearing, and clear colliding with a new overflow.
    op(1'b0, 2'd2, 1'b0, 8'h00);
    op(1'b0, 2'd3, 1'b0, 8'h00);
    check("pop3_unf",   32'(bus.underflow), 32'd1);
    check("pop3_count", 32'(bus.count),     32'd5);
    op(1'b0, 2'd0, 1'b1, 8'h00);
    check("clr_ovf", 32'(bus.overflow),  32'd0);
    check("clr_unf", 32'(bus.underflow), 32'd0);
    for (int i = 0; i < 3; i++) op(1'b1, 2'd0, 1'b0, 8'(8'h50 + i));
    op(1'b1, 2'd0, 1'b1, 8'h55);
    check("clr_set_ovf", 32'(bus.overflow), 32'd1);

    // Reset mid-stream.
    op(1'b0, 2'd2, 1'b0, 8'h00);
    op(1'b0, 2'd1, 1'b0, 8'h00);
    check("pre_rst_count", 32'(bus.count), 32'd5);
    reset = 1'b1;
    tick();
    check("mid_rst_count",   32'(bus.count),     32'd0);
    check("mid_rst_empty",   32'(bus.empty),     32'd1);
    check("mid_rst_r_addr0", 32'(bus.r_addr0),   32'd0);
    check("mid_rst_r_addr1", 32'(bus.r_addr1),   32'd1);
    check("mid_rst_ovf",     32'(bus.overflow),  32'd0);
    check("mid_rst_unf",     32'(bus.underflow), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fifo_ctrl_dual_pop

// File: doc/fifo_ctrl_dual_pop.md
Name: fifo_ctrl_dual_pop

Overview:
- Pointer/occupancy controller for a circular FIFO built on the team's 1-write/2-read register-file RAM. It drives the RAM's write address and both read addresses.
- Read port 0 always addresses the head word; read port 1 always addresses head+1. The consumer can therefore see two words and retire 0, 1 or 2 of them per cycle.
- Sits between the producer (push side), the RAM, and a consumer that wants two-word lookahead (e.g. a byte-pair parser).

Parameters:
- ADDR_WIDTH, 3, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH words.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- push  in  1  producer requests a write of the word currently on the RAM w_data bus.
- pop  in  2  words to retire this cycle: 0 none, 1 one, 2 two, 3 illegal.
- clr_err  in  1  clears the sticky error flags.
- we  out  1  RAM write enable (combinational).
- w_addr  out  ADDR_WIDTH  RAM write address = tail pointer.
- r_addr0  out  ADDR_WIDTH  RAM read address 0 = head pointer.
- r_addr1  out  ADDR_WIDTH  RAM read address 1 = head+1 mod DEPTH.
- count  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- has_two  out  1  count>=2; r_data1 is valid.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- One clock (clk); reset is synchronous and active-high; reset is sampled only on the rising edge of clk.
- Reset values:
  - tail=0, head=0, head_p1=1 (r_addr1=1), count=0.
  - empty=1, full=0, has_two=0, overflow=0, underflow=0.
  - Reset mid-operation discards all contents. RAM contents are untouched but are unreachable.
- Registers: tail, head, head_p1 and count are registers. empty, full and has_two are registered or derived purely from count, never from the inputs.
- Push acceptance:
  - push_ok = push & ~full, judged on the current count.
  - A push while full is rejected even if a pop occurs in the same cycle.
  - we = push_ok.
  - On push_ok, tail <= tail+1 with natural mod-DEPTH wrap.
- Pop acceptance:
  - pop=1 is accepted iff count>=1.
  - pop=2 is accepted iff count>=2.
  - A rejected pop (insufficient words, or pop=3) retires nothing, moves no pointer, and sets underflow. There is no partial pop.
  - Accepted pop of n words: head <= head+n, head_p1 <= head_p1+n, both mod DEPTH.
- Count update: count <= count + push_ok - pop_accepted_n. Width ADDR_WIDTH+1; it never wraps.
- Simultaneous events:
  - push and pop in the same cycle are both applied.
  - Full with pop=2 and push: push rejected, count = DEPTH-2.
  - Empty with push and pop=1: pop rejected (underflow set), push accepted, count=1.
  - No write-to-read bypass: a pushed word appears on r_data0/1 the cycle after the push edge.
- Read latency: the RAM is asynchronous-read, so r_data0/r_data1 reflect the new head combinationally after each pointer update edge.
- Error flags:
  - overflow is set on push & full; underflow is set on a rejected pop.
  - Both are cleared by clr_err.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Wrap-around: tail, head and head_p1 wrap from DEPTH-1 to 0. When head=DEPTH-1, r_addr1=0.

Decomposition:
- Shared constants go in a common include/package:
  - POP_NONE=2'd0, POP_ONE=2'd1, POP_TWO=2'd2.
  - The depth helper DEPTH = 1<<ADDR_WIDTH.
- No sub-module inside the controller.
- The natural parent is a wrapper fifo_dual_pop that instantiates this block plus the 3-port RAM, ties RAM we/w_addr/r_addr0/r_addr1 to it, and exports w_data/r_data0/r_data1.

Test Plan (ADDR_WIDTH=3, DEPTH=8, tested through the fifo_dual_pop wrapper):
- Reset, then push 8 words 0x10..0x17 -> count=8, full=1, r_data0=0x10, r_data1=0x11, w_addr=0. A 9th push -> we=0, overflow=1, count stays 8.
- From full, pop=2 four times -> the (r_data0,r_data1) pairs seen before each pop are (10,11), (12,13), (14,15), (16,17). Ends with empty=1, has_two=0, count=0.
- count=1 (word 0xA5), pop=2 -> underflow=1, count stays 1, r_data0 still 0xA5. Then pop=1 -> empty=1.
- Wrap: advance head to 7 with 9 words pushed across the wrap -> r_addr0=7, r_addr1=0, r_data1 is the word written at address 0. pop=2 -> head=1.
- Simultaneous: count=8, push+pop=1 -> push rejected, overflow=1, count=7. Then push+pop=1 -> accepted, count=7, tail advances by 1.
- pop=3 with count=5 -> underflow=1, count=5. clr_err with no new error -> overflow=0, underflow=0. clr_err together with a failing push -> overflow=1.
- Reset asserted mid-stream (count=5) -> next cycle count=0, empty=1, r_addr0=0, r_addr1=1, errors=0.
